hilo_mult_unit: RTL and testbench
=================================

Name: hilo_mult_unit

Overview:
Iterative shift-add multiplier with HI/LO result registers for the MIPS core's `mult`/`multu`/`mfhi`/`mflo`/`mthi`/`mtlo` instructions. It sits next to the ALU in the datapath and produces the 64-bit product consumed by the register write-back path. It uses a start/busy/done handshake so that the controller stalls while the multiply runs. It keeps the single-cycle datapath small and gives the Multiplikation test program its results.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  begin a multiply; sampled only in IDLE.
- is_signed  in  1  1 = `mult` (two's complement), 0 = `multu`; sampled with start.
- a  in  WIDTH  multiplicand (rs); sampled with start.
- b  in  WIDTH  multiplier (rt); sampled with start.
- hi_we  in  1  `mthi` write strobe.
- lo_we  in  1  `mtlo` write strobe.
- wdata  in  WIDTH  data for `mthi`/`mtlo`.
- busy  out  1  high while a multiply is in flight.
- done  out  1  one-cycle pulse when HI/LO take a new product.
- hi  out  WIDTH  HI register (`mfhi`).
- lo  out  WIDTH  LO register (`mflo`).

Behaviour:
- Reset (asynchronous, reset==0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0. Reset mid-operation aborts the multiply and leaves no partial result in HI/LO.
- States:
  - IDLE: on start=1 at edge E0, latch |a| and |b| (absolute values only when is_signed=1), latch neg = is_signed & (a[MSB]^b[MSB]), clear the 2*WIDTH accumulator and counter, go to CALC.
  - CALC: each edge, if the current multiplier LSB is 1, add the multiplicand (shifted to the current position) into the accumulator; shift; counter+1. After WIDTH edges (E1..E32), go to FINISH.
  - FINISH: at edge E33, {hi,lo} <= neg ? -acc : acc (2*WIDTH two's-complement negate). done=1 for the cycle after E33. Return to IDLE.
- Latency: result visible on hi/lo and done=1 in the cycle after E33, i.e. 33 clocks after start was sampled.
- busy: 1 from after E0 through E33 inclusive. busy=0 in the cycle where done=1, so a new start can be accepted on the same edge that ends the done cycle.
- start while busy: ignored; the operands in flight are unchanged.
- hi_we/lo_we in IDLE: the register takes wdata at the next edge; done is not asserted.
- hi_we/lo_we while busy: ignored. This is a compiler/controller hazard and the unit does not arbitrate it.
- hi_we and lo_we together: both registers load wdata.
- start and hi_we/lo_we together in IDLE: the mthi/mtlo write happens and the multiply starts. The multiply result later overwrites both registers.
- Width rules: |x| of the most negative value (0x80000000) is treated as unsigned 0x80000000, which is correct. The accumulator is 2*WIDTH bits with no overflow possible.
- hi/lo hold their value at all times except on a FINISH edge or an accepted mthi/mtlo.
- done is never high for more than one cycle.

Decomposition:
- Shared header (`include`, alongside the existing opcode/funct defines): state encodings IDLE/CALC/FINISH, and the MULT/MULTU/MFHI/MFLO/MTHI/MTLO funct constants used by the controller decode.
- No sub-module is needed. The single module holds the FSM, the shift-add datapath and the HI/LO registers.
- The controller integration (stall on busy, and the mfhi/mflo mux into write-back) lives in the existing datapath/controller, not here.

Test Plan:
- multu a=7, b=6 -> busy for 33 clocks; done pulse; hi=0x00000000, lo=0x0000002A.
- mult a=0xFFFFFFFB (-5), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFF1.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. mult a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Start a multiply of 2*3. Re-assert start with a=9, b=9 and pulse hi_we with wdata=0x1234 at cycle 10 -> both ignored; result hi=0, lo=6 at cycle 33.
- Start a multiply of 0xFFFF*0xFFFF and assert reset=0 at cycle 15 -> hi=lo=0, busy=0 and done=0 immediately (asynchronous). After release, no done pulse, and a fresh 4*5 gives lo=0x14.
- In IDLE: hi_we=1 with wdata=0xCAFEBABE, then lo_we=1 with wdata=0xDEADBEEF -> hi=0xCAFEBABE, lo=0xDEADBEEF, done stays 0.

Source files
------------

// File: rtl/hilo_mult_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: FSM state encodings
// and the R-type funct codes the controller decodes for this unit.
package hilo_mult_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } mult_state_e;

  // R-type funct field values (opcode SPECIAL)
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

endpackage

// File: rtl/hilo_mult_unit.sv
// Iterative shift-add multiplier with HI/LO result registers.
// Signed multiplies run on magnitudes; the sign is reapplied to the full
// 2*WIDTH product in FINISH. One product bit per clock in CALC.
module hilo_mult_unit
  import hilo_mult_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mult_state_e state, state_nxt;

  logic [2*WIDTH-1:0] mcand;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier;  // multiplier, shifted right each step
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] product;
  logic               last_step;

  // Magnitudes; the most negative value maps to itself, which is the
  // correct unsigned magnitude.
  assign a_abs     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_abs     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign product   = neg ? (~acc + 1'b1) : acc;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_CALC;
      ST_CALC:   if (last_step) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: busy covers CALC and FINISH, never the done cycle
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Shift-add datapath: load on accepted start, one step per CALC edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_abs};
            mplier <= b_abs;
            acc    <= '0;
            cnt    <= '0;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        ST_CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // HI/LO: product on FINISH, mthi/mtlo only while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FINISH) begin
      {hi, lo} <= product;
    end else if (state == ST_IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  // done pulses for exactly the cycle after the FINISH edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= (state == ST_FINISH);
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit: hand-computed products, handshake
// timing, ignored start/mthi while busy, async abort, idle HI/LO writes.
module tb_hilo_mult_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, is_signed, hi_we, lo_we;
  logic [WIDTH-1:0] a, b, wdata;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  hilo_mult_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // advance one edge, settle 1ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multiply and wait for done. lat = edges from start edge to done
  // (99 on timeout), busy_cnt = busy samples seen from start edge on.
  task automatic run_mult(input logic sg, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y,
                          output int lat, output int busy_cnt);
    start = 1'b1; is_signed = sg; a = x; b = y;
    tick();
    start = 1'b0;
    lat = 99;
    busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      if (busy) busy_cnt++;
      tick();
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_cmp++;
    if ({busy, done, hi, lo} !== {2'b00, 64'h0}) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hi, lo);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_multu_basic();
    int lat, bc;
    run_mult(1'b0, 32'd7, 32'd6, lat, bc);
    n_cmp++;
    if (lat !== 33) begin n_bad++; $display("FAIL multu7x6_latency: got %0d want 33", lat); end
    n_cmp++;
    if (bc !== 33) begin n_bad++; $display("FAIL multu7x6_busy_cycles: got %0d want 33", bc); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL multu7x6_busy_in_done: got %b want 0", busy); end
    n_cmp++;
    if ({hi, lo} !== 64'h00000000_0000002A) begin
      n_bad++; $display("FAIL multu7x6_result: got %h_%h want 00000000_0000002a", hi, lo);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL multu7x6_done_width: done=%b want 0", done); end
  endtask

  task automatic test_signed_mix();
    int lat, bc;
    run_mult(1'b1, 32'hFFFFFFFB, 32'd3, lat, bc);
    n_cmp++;
    if (lat !== 33 || {hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
      n_bad++; $display("FAIL mult_m5x3: lat=%0d got %h_%h want 33 ffffffff_fffffff1", lat, hi, lo);
    end
    // Back-to-back: start on the edge that ends the done cycle
    run_mult(1'b0, 32'hFFFFFFFB, 32'd3, lat, bc);
    n_cmp++;
    if (lat !== 33 || {hi, lo} !== 64'h00000002_FFFFFFF1) begin
      n_bad++; $display("FAIL multu_fffffffbx3: lat=%0d got %h_%h want 33 00000002_fffffff1", lat, hi, lo);
    end
    run_mult(1'b1, 32'd7, 32'hFFFFFFFA, lat, bc);
    n_cmp++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFD6) begin
      n_bad++; $display("FAIL mult_7xm6: got %h_%h want ffffffff_ffffffd6", hi, lo);
    end
  endtask

  task automatic test_boundaries();
    int lat, bc;
    run_mult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    n_cmp++;
    if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
      n_bad++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi, lo);
    end
    run_mult(1'b1, 32'h80000000, 32'h80000000, lat, bc);
    n_cmp++;
    if ({hi, lo} !== 64'h40000000_00000000) begin
      n_bad++; $display("FAIL mult_minneg_sq: got %h_%h want 40000000_00000000", hi, lo);
    end
    run_mult(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    n_cmp++;
    if ({hi, lo} !== 64'h00000000_00000001) begin
      n_bad++; $display("FAIL mult_m1xm1: got %h_%h want 00000000_00000001", hi, lo);
    end
  endtask

  task automatic test_ignore_while_busy();
    logic [WIDTH-1:0] hi_before;
    int lat;
    hi_before = hi;
    start = 1'b1; is_signed = 1'b0; a = 32'd2; b = 32'd3;
    tick();
    start = 1'b0;
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) begin
        start = 1'b1; a = 32'd9; b = 32'd9; hi_we = 1'b1; wdata = 32'h1234;
      end
      tick();
      if (n == 10) begin
        start = 1'b0; hi_we = 1'b0;
        n_cmp++;
        if (hi !== hi_before) begin
          n_bad++; $display("FAIL busy_mthi_ignored: hi=%h want %h", hi, hi_before);
        end
      end
      if (done) begin lat = n; break; end
    end
    n_cmp++;
    if (lat !== 33 || {hi, lo} !== 64'h00000000_00000006) begin
      n_bad++; $display("FAIL busy_start_ignored: lat=%0d got %h_%h want 33 00000000_00000006", lat, hi, lo);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_restart_ignored: busy=%b want 0", busy); end
  endtask

  task automatic test_async_abort();
    int lat, bc;
    logic seen_done;
    start = 1'b1; is_signed = 1'b0; a = 32'hFFFF; b = 32'hFFFF;
    tick();
    start = 1'b0;
    for (int n = 1; n < 15; n++) tick();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, hi, lo} !== {2'b00, 64'h0}) begin
      n_bad++; $display("FAIL abort_async: busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
    end
    tick();
    reset = 1'b1;
    seen_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0 || {hi, lo} !== 64'h0) begin
      n_bad++; $display("FAIL abort_no_result: activity=%b hi=%h lo=%h want 0", seen_done, hi, lo);
    end
    run_mult(1'b0, 32'd4, 32'd5, lat, bc);
    n_cmp++;
    if (lat !== 33 || {hi, lo} !== 64'h00000000_00000014) begin
      n_bad++; $display("FAIL abort_fresh_4x5: lat=%0d got %h_%h want 33 00000000_00000014", lat, hi, lo);
    end
  endtask

  task automatic test_idle_writes();
    int lat, bc;
    hi_we = 1'b1; wdata = 32'hCAFEBABE;
    tick();
    hi_we = 1'b0;
    n_cmp++;
    if (hi !== 32'hCAFEBABE || lo !== 32'h14 || done !== 1'b0) begin
      n_bad++; $display("FAIL mthi: hi=%h lo=%h done=%b want cafebabe 00000014 0", hi, lo, done);
    end
    lo_we = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    lo_we = 1'b0;
    n_cmp++;
    if (hi !== 32'hCAFEBABE || lo !== 32'hDEADBEEF || done !== 1'b0) begin
      n_bad++; $display("FAIL mtlo: hi=%h lo=%h done=%b want cafebabe deadbeef 0", hi, lo, done);
    end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h00005555;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    n_cmp++;
    if ({hi, lo} !== 64'h00005555_00005555) begin
      n_bad++; $display("FAIL mthi_mtlo_both: got %h_%h want 00005555_00005555", hi, lo);
    end
    // mthi together with start: write lands, product later overwrites
    hi_we = 1'b1; wdata = 32'h0BAD0BAD;
    start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd5;
    tick();
    hi_we = 1'b0; start = 1'b0;
    n_cmp++;
    if (hi !== 32'h0BAD0BAD || busy !== 1'b1) begin
      n_bad++; $display("FAIL start_with_mthi: hi=%h busy=%b want 0bad0bad 1", hi, busy);
    end
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin lat = n; break; end
    end
    n_cmp++;
    if (lat !== 33 || {hi, lo} !== 64'h00000000_0000000F) begin
      n_bad++; $display("FAIL start_with_mthi_result: lat=%0d got %h_%h want 33 00000000_0000000f", lat, hi, lo);
    end
    bc = 0;
  endtask

  initial begin
    start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    test_reset();
    test_multu_basic();
    test_signed_mix();
    test_boundaries();
    test_ignore_while_busy();
    test_async_abort();
    test_idle_writes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
